// File: rtl/pe_bypass_hist.sv
// pe_bypass_hist
// Operand bypass network between the IF-stage RF read and the ID stage of a PE.
// Each operand is resolved in this order:
//   1. an explicitly requested EX source
//   2. the write-back happening this cycle
//   3. the newest matching entry of a small write-back history
//   4. the RF read data
// The resolved operands then go through the neighbour/CP select, the immediate
// select and the RSUBI swap, and are registered into the ID stage. The ID
// registers support stall (hold with write-back refresh) and flush.
//
// Ports
//   iClk, iReset                     clock, asynchronous active-high reset
//   iStall, iFlush                   hold / kill ID-stage registers (flush wins)
//   iIF_Valid                        instruction presented this cycle
//   iWB_RF_Write_En/Addr/Data        RF write-back port
//   iIF_RF_Read_Addr_A/B             RF read addresses
//   iIF_BP_Bypass_Read_A/B, _Sel_A/B explicit EX bypass request and source index
//   iIF_BP_Select_Imm, iID_BP_Immediate, iID_BP_Is_SUB   immediate select / RSUBI
//   iRF_BP_Read_Data_A/B             RF read data
//   iEX_BP_Src_Data                  packed EX sources, source k at [k*DATA_W +: DATA_W]
//   iData_Selection                  10 left, 01 right, 11 CP, 00 own operand A
//   iLeft/iRight_PE_Port1_Data, iCP_Data   neighbour and CP broadcast data
//   oPE_Port1_Data                   combinational resolved A (before neighbour select)
//   oBP_ID_Valid, oBP_ID_Operand_A/B registered valid and operands
//   oBP_ID_LSU_Store_Data            registered resolved B (before imm select and swap)

module pe_bypass_hist #(
    parameter int DATA_W      = 32,
    parameter int RF_IDX_W    = 5,
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = 2,
    parameter int HIST_DEPTH  = 2,
    parameter int NO_BP_BELOW = 2
) (
    input  logic                      iClk,
    input  logic                      iReset,
    input  logic                      iStall,
    input  logic                      iFlush,
    input  logic                      iIF_Valid,
    input  logic                      iWB_RF_Write_En,
    input  logic [RF_IDX_W-1:0]       iWB_RF_Write_Addr,
    input  logic [DATA_W-1:0]         iWB_RF_Write_Data,
    input  logic [RF_IDX_W-1:0]       iIF_RF_Read_Addr_A,
    input  logic [RF_IDX_W-1:0]       iIF_RF_Read_Addr_B,
    input  logic                      iIF_BP_Bypass_Read_A,
    input  logic                      iIF_BP_Bypass_Read_B,
    input  logic [SEL_W-1:0]          iIF_BP_Bypass_Sel_A,
    input  logic [SEL_W-1:0]          iIF_BP_Bypass_Sel_B,
    input  logic                      iIF_BP_Select_Imm,
    input  logic [DATA_W-1:0]         iID_BP_Immediate,
    input  logic                      iID_BP_Is_SUB,
    input  logic [DATA_W-1:0]         iRF_BP_Read_Data_A,
    input  logic [DATA_W-1:0]         iRF_BP_Read_Data_B,
    input  logic [NUM_SRC*DATA_W-1:0] iEX_BP_Src_Data,
    input  logic [1:0]                iData_Selection,
    input  logic [DATA_W-1:0]         iLeft_PE_Port1_Data,
    input  logic [DATA_W-1:0]         iRight_PE_Port1_Data,
    input  logic [DATA_W-1:0]         iCP_Data,
    output logic [DATA_W-1:0]         oPE_Port1_Data,
    output logic                      oBP_ID_Valid,
    output logic [DATA_W-1:0]         oBP_ID_Operand_A,
    output logic [DATA_W-1:0]         oBP_ID_Operand_B,
    output logic [DATA_W-1:0]         oBP_ID_LSU_Store_Data
);

    localparam logic [RF_IDX_W-1:0] NO_BP_IDX = RF_IDX_W'(NO_BP_BELOW);

    logic [DATA_W-1:0]   src_arr   [NUM_SRC];
    logic [RF_IDX_W-1:0] hist_addr [HIST_DEPTH];
    logic [DATA_W-1:0]   hist_data [HIST_DEPTH];
    logic [HIST_DEPTH-1:0] hist_vld;

    // Writes to the low indices (r0, r1) are never forwarded from WB or history.
    logic wb_push;
    assign wb_push = iWB_RF_Write_En && (iWB_RF_Write_Addr >= NO_BP_IDX);

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            src_arr[k] = iEX_BP_Src_Data[k*DATA_W +: DATA_W];
        end
    end

    // History shift register, entry 0 newest. Keeps running while stalled.
    // A flush drops every old entry, but a write in the same cycle still lands.
    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            hist_vld <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_addr[i] <= '0;
                hist_data[i] <= '0;
            end
        end else if (wb_push) begin
            for (int i = HIST_DEPTH-1; i > 0; i--) begin
                hist_addr[i] <= hist_addr[i-1];
                hist_data[i] <= hist_data[i-1];
                hist_vld[i]  <= iFlush ? 1'b0 : hist_vld[i-1];
            end
            hist_addr[0] <= iWB_RF_Write_Addr;
            hist_data[0] <= iWB_RF_Write_Data;
            hist_vld[0]  <= 1'b1;
        end else if (iFlush) begin
            hist_vld <= '0;
        end
    end

    // Later assignments override earlier ones, so the code runs from the
    // lowest priority source up to the highest.
    function automatic logic [DATA_W-1:0] resolve(
        input logic [RF_IDX_W-1:0] addr,
        input logic                bp,
        input logic [SEL_W-1:0]    sel,
        input logic [DATA_W-1:0]   rf_data
    );
        logic [DATA_W-1:0] r;
        r = rf_data;
        for (int i = HIST_DEPTH-1; i >= 0; i--) begin
            if (hist_vld[i] && (hist_addr[i] == addr)) begin
                r = hist_data[i];
            end
        end
        if (wb_push && (iWB_RF_Write_Addr == addr)) begin
            r = iWB_RF_Write_Data;
        end
        if (bp) begin
            // An out-of-range select falls back to source 0.
            r = src_arr[0];
            for (int k = 0; k < NUM_SRC; k++) begin
                if (int'(sel) == k) begin
                    r = src_arr[k];
                end
            end
        end
        return r;
    endfunction

    logic [DATA_W-1:0]   res_a, res_b, a_n, b_i;
    logic                a_n_rf, b_i_rf, swap;
    logic [DATA_W-1:0]   nxt_a, nxt_b;
    logic                nxt_a_rf, nxt_b_rf;
    logic [RF_IDX_W-1:0] nxt_a_addr, nxt_b_addr;

    always_comb begin
        res_a = resolve(iIF_RF_Read_Addr_A, iIF_BP_Bypass_Read_A, iIF_BP_Bypass_Sel_A,
                        iRF_BP_Read_Data_A);
        res_b = resolve(iIF_RF_Read_Addr_B, iIF_BP_Bypass_Read_B, iIF_BP_Bypass_Sel_B,
                        iRF_BP_Read_Data_B);

        case (iData_Selection)
            2'b10:   a_n = iLeft_PE_Port1_Data;
            2'b01:   a_n = iRight_PE_Port1_Data;
            2'b11:   a_n = iCP_Data;
            default: a_n = res_a;
        endcase
        // Only values that came from the RF side (RF, WB or history) may be
        // refreshed by a later write-back during a stall.
        a_n_rf = !iIF_BP_Bypass_Read_A && (iData_Selection == 2'b00);

        b_i    = iIF_BP_Select_Imm ? iID_BP_Immediate : res_b;
        b_i_rf = !iIF_BP_Bypass_Read_B && !iIF_BP_Select_Imm;

        swap       = iID_BP_Is_SUB && iIF_BP_Select_Imm;
        nxt_a      = swap ? b_i                : a_n;
        nxt_a_rf   = swap ? b_i_rf             : a_n_rf;
        nxt_a_addr = swap ? iIF_RF_Read_Addr_B : iIF_RF_Read_Addr_A;
        nxt_b      = swap ? a_n                : b_i;
        nxt_b_rf   = swap ? a_n_rf             : b_i_rf;
        nxt_b_addr = swap ? iIF_RF_Read_Addr_A : iIF_RF_Read_Addr_B;
    end

    assign oPE_Port1_Data = res_a;

    logic                held_a_rf, held_b_rf, held_sd_rf;
    logic [RF_IDX_W-1:0] held_a_addr, held_b_addr, held_sd_addr;

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            oBP_ID_Valid          <= 1'b0;
            oBP_ID_Operand_A      <= '0;
            oBP_ID_Operand_B      <= '0;
            oBP_ID_LSU_Store_Data <= '0;
            held_a_rf             <= 1'b0;
            held_b_rf             <= 1'b0;
            held_sd_rf            <= 1'b0;
            held_a_addr           <= '0;
            held_b_addr           <= '0;
            held_sd_addr          <= '0;
        end else if (iFlush) begin
            oBP_ID_Valid          <= 1'b0;
            oBP_ID_Operand_A      <= '0;
            oBP_ID_Operand_B      <= '0;
            oBP_ID_LSU_Store_Data <= '0;
            held_a_rf             <= 1'b0;
            held_b_rf             <= 1'b0;
            held_sd_rf            <= 1'b0;
        end else if (!iStall) begin
            oBP_ID_Valid          <= iIF_Valid;
            oBP_ID_Operand_A      <= nxt_a;
            oBP_ID_Operand_B      <= nxt_b;
            oBP_ID_LSU_Store_Data <= res_b;
            held_a_rf             <= nxt_a_rf;
            held_b_rf             <= nxt_b_rf;
            held_sd_rf            <= !iIF_BP_Bypass_Read_B;
            held_a_addr           <= nxt_a_addr;
            held_b_addr           <= nxt_b_addr;
            held_sd_addr          <= iIF_RF_Read_Addr_B;
        end else begin
            // Stalled: hold, but keep RF-sourced operands coherent with new writes.
            if (wb_push && held_a_rf && (iWB_RF_Write_Addr == held_a_addr)) begin
                oBP_ID_Operand_A <= iWB_RF_Write_Data;
            end
            if (wb_push && held_b_rf && (iWB_RF_Write_Addr == held_b_addr)) begin
                oBP_ID_Operand_B <= iWB_RF_Write_Data;
            end
            if (wb_push && held_sd_rf && (iWB_RF_Write_Addr == held_sd_addr)) begin
                oBP_ID_LSU_Store_Data <= iWB_RF_Write_Data;
            end
        end
    end

endmodule

// File: tb/tb_pe_bypass_hist.sv
module tb_pe_bypass_hist;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, if_valid;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW-1:0] addr_a, addr_b;
    logic          bp_a, bp_b;
    logic [SW-1:0] sel_a, sel_b;
    logic          sel_imm, is_sub;
    logic [DW-1:0] imm, rf_a, rf_b;
    logic [NS*DW-1:0] src;
    logic [1:0]    data_sel;
    logic [DW-1:0] left_d, right_d, cp_d;
    logic [DW-1:0] port1, op_a, op_b, st_data;
    logic          id_valid;

    pe_bypass_hist #(
        .DATA_W(DW), .RF_IDX_W(AW), .NUM_SRC(NS), .SEL_W(SW),
        .HIST_DEPTH(2), .NO_BP_BELOW(2)
    ) dut (
        .iClk(clk), .iReset(rst), .iStall(stall), .iFlush(flush), .iIF_Valid(if_valid),
        .iWB_RF_Write_En(wb_en), .iWB_RF_Write_Addr(wb_addr), .iWB_RF_Write_Data(wb_data),
        .iIF_RF_Read_Addr_A(addr_a), .iIF_RF_Read_Addr_B(addr_b),
        .iIF_BP_Bypass_Read_A(bp_a), .iIF_BP_Bypass_Read_B(bp_b),
        .iIF_BP_Bypass_Sel_A(sel_a), .iIF_BP_Bypass_Sel_B(sel_b),
        .iIF_BP_Select_Imm(sel_imm), .iID_BP_Immediate(imm), .iID_BP_Is_SUB(is_sub),
        .iRF_BP_Read_Data_A(rf_a), .iRF_BP_Read_Data_B(rf_b),
        .iEX_BP_Src_Data(src), .iData_Selection(data_sel),
        .iLeft_PE_Port1_Data(left_d), .iRight_PE_Port1_Data(right_d), .iCP_Data(cp_d),
        .oPE_Port1_Data(port1), .oBP_ID_Valid(id_valid),
        .oBP_ID_Operand_A(op_a), .oBP_ID_Operand_B(op_b),
        .oBP_ID_LSU_Store_Data(st_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        int          id;
        logic        vld;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every expectation whose output cycle has arrived.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.due == cyc && id_valid === e.vld && op_a === e.a && op_b === e.b
                && st_data === e.sd) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d: got vld=%0b a=%h b=%h sd=%h, want vld=%0b a=%h b=%h sd=%h",
                         e.id, id_valid, op_a, op_b, st_data, e.vld, e.a, e.b, e.sd);
            end
        end
    end

    task automatic push(input int id, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] sd);
        sb.push_back('{cyc + 1, id, v, a, b, sd});
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    task automatic chk_zero(input string name);
        n_checks++;
        if (id_valid === 1'b0 && op_a === '0 && op_b === '0 && st_data === '0) n_pass++;
        else $display("FAIL %s: got vld=%0b a=%h b=%h sd=%h, want all zero",
                      name, id_valid, op_a, op_b, st_data);
    endtask

    task automatic defaults();
        stall = 0; flush = 0; if_valid = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0;
        addr_a = '0; addr_b = '0; bp_a = 0; bp_b = 0; sel_a = '0; sel_b = '0;
        sel_imm = 0; is_sub = 0; imm = '0; rf_a = '0; rf_b = '0;
        src = '0; data_sel = 2'b00; left_d = '0; right_d = '0; cp_d = '0;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        defaults();
        rst = 1;
        repeat (3) tick();
        chk_zero("reset_state");
        rst = 0;

        // history hit
        defaults(); wb(5, 32'h11); push(0, 0, 0, 0, 0); tick();
        defaults(); if_valid = 1; addr_a = 5; #1 chk("port1_hist", port1, 32'h11);
        push(1, 1, 32'h11, 0, 0); tick();
        // newest history entry wins; oldest drops out
        defaults(); wb(7, 32'h1); tick();
        defaults(); wb(7, 32'h2); tick();
        defaults(); if_valid = 1; addr_a = 7; rf_a = 32'hdead; addr_b = 5; rf_b = 32'h77;
        push(4, 1, 32'h2, 32'h77, 32'h77); tick();
        // r1 never bypassed, neither from WB nor from history
        defaults(); wb(1, 32'h99); if_valid = 1; addr_a = 1; rf_a = 32'h33;
        push(5, 1, 32'h33, 0, 0); tick();
        defaults(); if_valid = 1; addr_a = 1; rf_a = 32'h44; addr_b = 7; rf_b = 32'h10;
        push(6, 1, 32'h44, 32'h2, 32'h2); tick();
        // explicit EX bypass
        defaults(); if_valid = 1; src = {32'hABCD, 32'h5678, 32'h1234}; bp_b = 1; sel_b = 2;
        push(7, 1, 0, 32'hABCD, 32'hABCD); tick();
        defaults(); if_valid = 1; src = {32'hABCD, 32'h5678, 32'h1234}; bp_b = 1; sel_b = 3;
        push(8, 1, 0, 32'h1234, 32'h1234); tick();
        defaults(); if_valid = 1; src = {32'hABCD, 32'h5678, 32'h1234};
        bp_a = 1; sel_a = 1; bp_b = 1; sel_b = 0;
        push(9, 1, 32'h5678, 32'h1234, 32'h1234); tick();
        // RSUBI swap, then with CP select
        defaults(); if_valid = 1; addr_a = 4; rf_a = 9; imm = 3; sel_imm = 1; is_sub = 1;
        rf_b = 32'h21;
        push(10, 1, 3, 9, 32'h21); tick();
        defaults(); if_valid = 1; addr_a = 4; rf_a = 9; imm = 3; sel_imm = 1; is_sub = 1;
        rf_b = 32'h21; data_sel = 2'b11; cp_d = 32'h55;
        #1 chk("port1_cp", port1, 32'h9);
        push(11, 1, 3, 32'h55, 32'h21); tick();
        // neighbour selects, immediate without swap
        defaults(); if_valid = 1; addr_a = 4; rf_a = 9; rf_b = 32'h21; data_sel = 2'b10;
        left_d = 32'h100; right_d = 32'h200;
        push(12, 1, 32'h100, 32'h21, 32'h21); tick();
        defaults(); if_valid = 1; addr_a = 4; rf_a = 9; rf_b = 32'h21; data_sel = 2'b01;
        left_d = 32'h100; right_d = 32'h200; sel_imm = 1; imm = 3;
        push(13, 1, 32'h200, 3, 32'h21); tick();
        // stall with refresh of an RF-sourced operand
        defaults(); wb(9, 32'h4); tick();
        defaults(); if_valid = 1; addr_a = 9; rf_b = 5;
        push(15, 1, 4, 5, 5); tick();
        defaults(); stall = 1; push(16, 1, 4, 5, 5); tick();
        defaults(); stall = 1; wb(9, 32'h8); push(17, 1, 8, 5, 5); tick();
        defaults(); stall = 1; push(18, 1, 8, 5, 5); tick();
        defaults(); push(19, 0, 0, 0, 0); tick();
        // stall with an EX-sourced operand: no refresh
        defaults(); if_valid = 1; addr_a = 9; bp_a = 1; sel_a = 1;
        src = {32'hABCD, 32'h5678, 32'h1234}; rf_b = 5;
        push(20, 1, 32'h5678, 5, 5); tick();
        defaults(); stall = 1; wb(9, 32'h66); push(21, 1, 32'h5678, 5, 5); tick();
        // refresh follows the swapped position
        defaults(); if_valid = 1; addr_a = 9; imm = 3; sel_imm = 1; is_sub = 1; rf_b = 5;
        push(22, 1, 3, 32'h66, 5); tick();
        defaults(); stall = 1; wb(9, 32'h77); push(23, 1, 3, 32'h77, 5); tick();
        // flush beats stall and clears history
        defaults(); if_valid = 1; addr_a = 9; push(24, 1, 32'h77, 0, 0); tick();
        defaults(); stall = 1; flush = 1; push(25, 0, 0, 0, 0); tick();
        defaults(); if_valid = 1; addr_a = 9; rf_a = 3; push(26, 1, 3, 0, 0); tick();
        defaults(); stall = 1; push(27, 1, 3, 0, 0); tick();
        // async reset in the middle of a stall
        defaults(); stall = 1;
        #2 rst = 1;
        #1 chk_zero("async_reset_mid_stall");
        tick();
        rst = 0;
        repeat (2) tick();

        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
